// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-class 16x2 LCD controller:
//   - sequencer and byte-writer state enums
//   - LCD command opcodes used by init and refresh
//   - helpers that map a sequence index to the byte to send
// ---------------------------------------------------------------------------
package lcd_pkg;

  // Top-level sequencing: wait after power-up, send init bytes, rewrite rows, rest.
  typedef enum logic [1:0] {
    SEQ_POWERUP,
    SEQ_INIT,
    SEQ_REFRESH,
    SEQ_IDLE
  } seq_state_t;

  // Per-byte bus phases driven by the byte writer.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } phase_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, no cursor
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // auto-increment, no shift
  localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (slow command)
  localparam logic [7:0] CMD_ROW0     = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_ROW1     = 8'hC0;  // DDRAM address 0x40

  localparam int INIT_BYTES    = 4;
  localparam int REFRESH_BYTES = 34;

  // Init command for a given position in the power-up sequence.
  function automatic logic [7:0] init_byte(input logic [5:0] idx);
    case (idx)
      6'd0:    return CMD_FUNC_SET;
      6'd1:    return CMD_DISP_ON;
      6'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  // {rs, data} for refresh byte idx. The snapshot is {top, bottom} with
  // column 0 of the top row in the most significant byte, so the 32
  // characters appear in display order from MSB down.
  function automatic logic [8:0] refresh_byte(input logic [5:0] idx,
                                              input logic [255:0] snap);
    int col;
    if (idx == 6'd0)  return {1'b0, CMD_ROW0};
    if (idx == 6'd17) return {1'b0, CMD_ROW1};
    col = (idx <= 6'd16) ? int'(idx) - 1 : int'(idx) - 2;
    return {1'b1, 8'(snap >> (8 * (31 - col)))};
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// ---------------------------------------------------------------------------
// lcd_byte_writer
// Drives one byte onto the LCD bus with setup / enable pulse / hold timing.
// A new start is accepted when idle or in the last hold cycle, so bytes can
// be chained with no dead cycles.
// Ports:
//   clk, nRst   clock, async active-low reset
//   start       request to send data/rs (accepted when idle or done)
//   data, rs    byte and register select for the request
//   long_wait   use the long post-byte wait (clear command)
//   done        high in the final hold cycle of the current byte
//   lcd_en      enable strobe (registered)
//   lcd_rs      register select (registered, held after the byte)
//   lcd_data    data bus (registered, held after the byte)
// ---------------------------------------------------------------------------
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int EN_CYC    = 5,
  parameter int WAIT_CYC  = 500,
  parameter int CLEAR_CYC = 20000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       rs,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int MAX_A   = (EN_CYC > WAIT_CYC) ? EN_CYC : WAIT_CYC;
  localparam int CNT_MAX = (MAX_A > CLEAR_CYC) ? MAX_A : CLEAR_CYC;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  phase_t             phase;
  logic [CNT_W-1:0]   cnt;
  logic               long_q;
  logic [CNT_W-1:0]   hold_last;
  logic               accept;

  assign hold_last = long_q ? CNT_W'(CLEAR_CYC - 1) : CNT_W'(WAIT_CYC - 1);
  assign done      = (phase == PH_HOLD) && (cnt == hold_last);
  assign accept    = start && ((phase == PH_IDLE) || done);

  // Phase engine: SETUP is a single cycle, PULSE and HOLD count their lengths.
  // Data and rs are only loaded on accept, so they stay stable for the whole
  // byte and keep the last value while idle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (accept) begin
      phase    <= PH_SETUP;
      cnt      <= '0;
      long_q   <= long_wait;
      lcd_en   <= 1'b0;
      lcd_rs   <= rs;
      lcd_data <= data;
    end else begin
      case (phase)
        PH_SETUP: begin
          phase  <= PH_PULSE;
          cnt    <= '0;
          lcd_en <= 1'b1;
        end
        PH_PULSE: begin
          if (cnt == CNT_W'(EN_CYC - 1)) begin
            phase  <= PH_HOLD;
            cnt    <= '0;
            lcd_en <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_HOLD: begin
          if (done) begin
            phase <= PH_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_IDLE: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd1602_controller.sv
// ---------------------------------------------------------------------------
// lcd1602_controller
// Sequences a 16x2 HD44780-class LCD in 8-bit write-only mode: power-up
// wait, init commands, then a full two-row rewrite whenever the image
// changes or update is pulsed.
// Ports:
//   clk, nRst   clock, async active-low reset
//   top         row 0 image, [127:120] is column 0
//   bottom      row 1 image, same packing
//   update      force one refresh even if the image is unchanged
//   lcd_en      enable strobe
//   lcd_rs      0 = command, 1 = data
//   lcd_rw      always 0 (write only)
//   lcd_data    data bus
//   ready       init complete
//   busy        init or refresh in progress (0 only when idle)
// ---------------------------------------------------------------------------
module lcd1602_controller
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC = 400000,
  parameter int EN_CYC      = 5,
  parameter int WAIT_CYC    = 500,
  parameter int CLEAR_CYC   = 20000
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [127:0] top,
  input  logic [127:0] bottom,
  input  logic         update,
  output logic         lcd_en,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         ready,
  output logic         busy
);

  localparam int CNT_MAX = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  seq_state_t       state, state_nx;
  logic [CNT_W-1:0] pwr_cnt;
  logic [5:0]       idx;
  logic [255:0]     snapshot;
  logic             pending;
  logic             trigger;
  logic             load_snap;
  logic             wr_start;
  logic [7:0]       wr_data;
  logic             wr_rs;
  logic             wr_long;
  logic             wr_done;

  assign lcd_rw = 1'b0;

  // Next-byte selection. Each new byte is requested in the same cycle the
  // writer reports done, which keeps the byte period free of gaps. Starting
  // a refresh always sends the row-0 address first, so the snapshot can be
  // loaded in that same cycle and is valid before the first character.
  always_comb begin
    state_nx  = state;
    wr_start  = 1'b0;
    wr_data   = 8'h00;
    wr_rs     = 1'b0;
    wr_long   = 1'b0;
    load_snap = 1'b0;
    trigger   = ready && (({top, bottom} != snapshot) || update || pending);
    case (state)
      SEQ_POWERUP: begin
        if (pwr_cnt == CNT_W'(POWERUP_CYC - 1)) begin
          wr_start = 1'b1;
          wr_data  = init_byte(6'd0);
          state_nx = SEQ_INIT;
        end
      end
      SEQ_INIT: begin
        if (wr_done) begin
          wr_start = 1'b1;
          if (idx == 6'(INIT_BYTES - 1)) begin
            wr_data   = CMD_ROW0;
            load_snap = 1'b1;
            state_nx  = SEQ_REFRESH;
          end else begin
            wr_data = init_byte(idx + 6'd1);
          end
        end
      end
      SEQ_REFRESH: begin
        if (wr_done) begin
          if (idx == 6'(REFRESH_BYTES - 1)) begin
            state_nx = SEQ_IDLE;
          end else begin
            wr_start         = 1'b1;
            {wr_rs, wr_data} = refresh_byte(idx + 6'd1, snapshot);
          end
        end
      end
      SEQ_IDLE: begin
        if (trigger) begin
          wr_start  = 1'b1;
          wr_data   = CMD_ROW0;
          load_snap = 1'b1;
          state_nx  = SEQ_REFRESH;
        end
      end
    endcase
    // Only the clear command needs the long settle time; a character code
    // of 0x01 sent as data does not.
    wr_long = wr_start && !wr_rs && (wr_data == CMD_CLEAR);
  end

  // Sequencer registers. The byte index restarts on every state change and
  // advances once per requested byte. An update seen while busy is parked
  // in pending so it is honoured once the current pass finishes; starting
  // a refresh consumes it.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= SEQ_POWERUP;
      pwr_cnt  <= '0;
      idx      <= 6'd0;
      snapshot <= '0;
      pending  <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != SEQ_IDLE);

      if ((state == SEQ_POWERUP) && (state_nx == SEQ_POWERUP))
        pwr_cnt <= pwr_cnt + 1'b1;
      else
        pwr_cnt <= '0;

      if (state_nx != state)
        idx <= 6'd0;
      else if (wr_start)
        idx <= idx + 6'd1;

      if ((state == SEQ_INIT) && (state_nx == SEQ_REFRESH))
        ready <= 1'b1;

      if (load_snap) begin
        snapshot <= {top, bottom};
        pending  <= 1'b0;
      end else if (update) begin
        pending <= 1'b1;
      end
    end
  end

  lcd_byte_writer #(
    .EN_CYC   (EN_CYC),
    .WAIT_CYC (WAIT_CYC),
    .CLEAR_CYC(CLEAR_CYC)
  ) u_writer (
    .clk      (clk),
    .nRst     (nRst),
    .start    (wr_start),
    .data     (wr_data),
    .rs       (wr_rs),
    .long_wait(wr_long),
    .done     (wr_done),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data)
  );

endmodule
